// File: rtl/cpu_stack_pkg.sv
// Shared stack-transfer definitions: op codes, sequencer states, P bit positions
// and the op-to-byte-count helper.
package cpu_stack_pkg;

  localparam logic [7:0]  STACK_PAGE_DEFAULT = 8'h01;
  localparam int unsigned ADDR_W_DEFAULT     = 16;
  localparam int unsigned P_B_BIT            = 4;
  localparam int unsigned P_U_BIT            = 5;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_INC  = 2'b01;
  localparam logic [1:0] SEL_DEC  = 2'b10;

  typedef enum logic [2:0] {
    OP_PUSH1    = 3'b000,
    OP_PULL1    = 3'b001,
    OP_PUSH_PC  = 3'b010,
    OP_PUSH_INT = 3'b011,
    OP_PULL_PC  = 3'b100,
    OP_PULL_INT = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Bytes moved per op; 0 marks a reserved encoding.
  function automatic logic [1:0] op_count(input logic [2:0] op);
    case (op)
      OP_PUSH1, OP_PULL1:       op_count = 2'd1;
      OP_PUSH_PC, OP_PULL_PC:   op_count = 2'd2;
      OP_PUSH_INT, OP_PULL_INT: op_count = 2'd3;
      default:                  op_count = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_push(input logic [2:0] op);
    op_is_push = (op == OP_PUSH1) || (op == OP_PUSH_PC) || (op == OP_PUSH_INT);
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Sequences multi-byte 6502 stack pushes/pulls against an external stack
// pointer, forming page-1 addresses and returning pulled bytes.
module stack_sequencer
  import cpu_stack_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEFAULT,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              brk,
  input  logic [7:0]        push_data,
  input  logic [15:0]       pc,
  input  logic [7:0]        status,
  input  logic [7:0]        sp,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        sp_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        pull_data,
  output logic [15:0]       pc_out,
  output logic [7:0]        p_out
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  n_q, n_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic        access_q, access_d;
  logic [1:0]  sp_sel_q, sp_sel_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  pull_data_q, pull_data_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  p_out_q, p_out_d;
  logic [7:0]  p_int;

  // Byte written by access idx of a push op (high byte first, P last).
  function automatic logic [7:0] push_byte(input logic [2:0] o, input logic [1:0] i,
                                           input logic [15:0] p_c, input logic [7:0] p_s,
                                           input logic [7:0] d);
    case (o)
      OP_PUSH1:    push_byte = d;
      OP_PUSH_PC:  push_byte = (i == 2'd0) ? p_c[15:8] : p_c[7:0];
      OP_PUSH_INT: push_byte = (i == 2'd0) ? p_c[15:8] : (i == 2'd1) ? p_c[7:0] : p_s;
      default:     push_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    p_int          = status;
    p_int[P_U_BIT] = 1'b1;
    p_int[P_B_BIT] = brk;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    n_d         = n_q;
    pc_d        = pc_q;
    p_d         = p_q;
    data_d      = data_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    pull_data_d = pull_data_q;
    pc_out_d    = pc_out_q;
    p_out_d     = p_out_q;
    access_d    = 1'b0;
    sp_sel_d    = SEL_HOLD;
    wdata_d     = 8'h00;
    we_d        = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          pc_d   = pc;
          p_d    = p_int;
          data_d = push_data;
          idx_d  = 2'd0;
          n_d    = op_count(op);
          if (op_count(op) == 2'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_XFER;
            access_d = 1'b1;
            busy_d   = 1'b1;
            if (op_is_push(op)) begin
              we_d     = 1'b1;
              sp_sel_d = SEL_DEC;
              wdata_d  = push_byte(op, 2'd0, pc, p_int, push_data);
            end else begin
              sp_sel_d = SEL_INC;
            end
          end
        end
      end

      ST_XFER: begin
        // Read data for the previous pull address is on mem_rdata now.
        if (!op_is_push(op_q)) begin
          if (idx_q == 2'd1) b0_d = mem_rdata;
          if (idx_q == 2'd2) b1_d = mem_rdata;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == n_q - 2'd1) begin
          if (op_is_push(op_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            busy_d  = 1'b1;
          end
        end else begin
          busy_d   = 1'b1;
          access_d = 1'b1;
          if (op_is_push(op_q)) begin
            we_d     = 1'b1;
            sp_sel_d = SEL_DEC;
            wdata_d  = push_byte(op_q, idx_q + 2'd1, pc_q, p_q, data_q);
          end else begin
            sp_sel_d = SEL_INC;
          end
        end
      end

      ST_WAIT: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        case (op_q)
          OP_PULL1:    pull_data_d = mem_rdata;
          OP_PULL_PC:  pc_out_d    = {mem_rdata, b0_q};
          OP_PULL_INT: begin
            p_out_d  = b0_q;
            pc_out_d = {mem_rdata, b1_q};
          end
          default: ;
        endcase
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'b000;
      idx_q       <= 2'd0;
      n_q         <= 2'd0;
      pc_q        <= 16'h0000;
      p_q         <= 8'h00;
      data_q      <= 8'h00;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      access_q    <= 1'b0;
      sp_sel_q    <= SEL_HOLD;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pull_data_q <= 8'h00;
      pc_out_q    <= 16'h0000;
      p_out_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      pc_q        <= pc_d;
      p_q         <= p_d;
      data_q      <= data_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      access_q    <= access_d;
      sp_sel_q    <= sp_sel_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pull_data_q <= pull_data_d;
      pc_out_q    <= pc_out_d;
      p_out_q     <= p_out_d;
    end
  end

  // sp already reflects the pending increment on pulls, so it is used live.
  assign addr      = access_q ? ADDR_W'({STACK_PAGE, sp}) : '0;
  assign sp_sel    = sp_sel_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pull_data = pull_data_q;
  assign pc_out    = pc_out_q;
  assign p_out     = p_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a saturating stack-pointer model
// and a page-1 memory model returning read data one cycle after the address.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        brk;
  logic [7:0]  push_data;
  logic [15:0] pc;
  logic [7:0]  status;
  logic [7:0]  sp;
  logic [7:0]  mem_rdata;
  logic [1:0]  sp_sel;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  pull_data;
  logic [15:0] pc_out;
  logic [7:0]  p_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sp_cnt = 8'h00;
  logic       sp_load = 1'b0;
  logic [7:0] sp_load_val = 8'h00;
  logic [7:0] mem [256];
  logic       mem_ld = 1'b0;
  logic [7:0] mem_ld_addr = 8'h00;
  logic [7:0] mem_ld_val = 8'h00;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .brk(brk),
    .push_data(push_data), .pc(pc), .status(status), .sp(sp),
    .mem_rdata(mem_rdata), .sp_sel(sp_sel), .addr(addr), .wdata(wdata),
    .we(we), .busy(busy), .done(done), .err(err), .pull_data(pull_data),
    .pc_out(pc_out), .p_out(p_out)
  );

  // Stack pointer model: pulls present counter+1 combinationally, saturating.
  assign sp = (sp_sel == 2'b01) ? ((sp_cnt == 8'hFF) ? 8'hFF : sp_cnt + 8'd1) : sp_cnt;

  always @(posedge clk) begin
    if (sp_load) sp_cnt <= sp_load_val;
    else if (sp_sel == 2'b01) sp_cnt <= (sp_cnt == 8'hFF) ? 8'hFF : sp_cnt + 8'd1;
    else if (sp_sel == 2'b10) sp_cnt <= (sp_cnt == 8'h00) ? 8'h00 : sp_cnt - 8'd1;
  end

  always @(posedge clk) begin
    if (mem_ld) mem[mem_ld_addr] <= mem_ld_val;
    else if (we) mem[addr[7:0]] <= wdata;
    mem_rdata <= mem[addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_sp(input logic [7:0] v);
    sp_load = 1'b1; sp_load_val = v;
    @(posedge clk); #1 sp_load = 1'b0;
    tick();
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    mem_ld = 1'b1; mem_ld_addr = a; mem_ld_val = v;
    @(posedge clk); #1 mem_ld = 1'b0;
    tick();
  endtask

  // Called at a negedge; returns inside cycle 1 (start sampled at edge 0).
  task automatic kick(input logic [2:0] o, input logic [7:0] d, input logic [15:0] p_c,
                      input logic [7:0] st, input logic b);
    start = 1'b1; op = o; push_data = d; pc = p_c; status = st; brk = b;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_we"}, 32'(we), 32'h0);
    check_eq({tag, "_sel"}, 32'(sp_sel), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0; start = 1'b0; op = 3'b000; brk = 1'b0;
    push_data = 8'h00; pc = 16'h0000; status = 8'h00;
    repeat (3) tick();
    check_idle("rst");
    check_eq("rst_addr", 32'(addr), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_wdata", 32'(wdata), 32'h0);
    check_eq("rst_pcout", 32'(pc_out), 32'h0);
    reset = 1'b1;
    tick();

    // Reset asserted during cycle 2 of PUSH_INT aborts it
    set_sp(8'hFF);
    kick(3'b011, 8'h00, 16'hABCD, 8'hC3, 1'b1);
    tick();
    check_eq("abort_c1_we", 32'(we), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    check_idle("abort_c3");
    check_eq("abort_addr", 32'(addr), 32'h0);
    check_eq("abort_pcout", 32'(pc_out), 32'h0);
    check_eq("abort_pout", 32'(p_out), 32'h0);
    check_eq("abort_pull", 32'(pull_data), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_after");
    end

    // PUSH_PC at sp=FD
    set_sp(8'hFD);
    kick(3'b010, 8'h00, 16'hC123, 8'h00, 1'b0);
    tick();
    check_eq("pushpc_c1_addr", 32'(addr), 32'h01FD);
    check_eq("pushpc_c1_wdata", 32'(wdata), 32'hC1);
    check_eq("pushpc_c1_we", 32'(we), 32'h1);
    check_eq("pushpc_c1_sel", 32'(sp_sel), 32'h2);
    check_eq("pushpc_c1_busy", 32'(busy), 32'h1);
    tick();
    check_eq("pushpc_c2_addr", 32'(addr), 32'h01FC);
    check_eq("pushpc_c2_wdata", 32'(wdata), 32'h23);
    check_eq("pushpc_c2_sel", 32'(sp_sel), 32'h2);
    check_eq("pushpc_c2_done", 32'(done), 32'h0);
    tick();
    check_eq("pushpc_c3_done", 32'(done), 32'h1);
    check_eq("pushpc_c3_we", 32'(we), 32'h0);
    check_eq("pushpc_c3_busy", 32'(busy), 32'h0);
    check_eq("pushpc_c3_addr", 32'(addr), 32'h0);
    check_eq("pushpc_sp", 32'(sp_cnt), 32'hFB);
    check_eq("pushpc_memFD", 32'(mem[8'hFD]), 32'hC1);
    check_eq("pushpc_memFC", 32'(mem[8'hFC]), 32'h23);
    tick();
    check_eq("pushpc_c4_done", 32'(done), 32'h0);

    // PULL_INT from counter FA
    poke(8'hFB, 8'hA5);
    poke(8'hFC, 8'h34);
    poke(8'hFD, 8'h12);
    set_sp(8'hFA);
    kick(3'b101, 8'h00, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("pullint_c1_addr", 32'(addr), 32'h01FB);
    check_eq("pullint_c1_sel", 32'(sp_sel), 32'h1);
    check_eq("pullint_c1_we", 32'(we), 32'h0);
    tick();
    check_eq("pullint_c2_addr", 32'(addr), 32'h01FC);
    tick();
    check_eq("pullint_c3_addr", 32'(addr), 32'h01FD);
    tick();
    check_eq("pullint_c4_busy", 32'(busy), 32'h1);
    check_eq("pullint_c4_done", 32'(done), 32'h0);
    check_eq("pullint_c4_sel", 32'(sp_sel), 32'h0);
    tick();
    check_eq("pullint_c5_done", 32'(done), 32'h1);
    check_eq("pullint_c5_busy", 32'(busy), 32'h0);
    check_eq("pullint_pout", 32'(p_out), 32'hA5);
    check_eq("pullint_pcout", 32'(pc_out), 32'h1234);
    check_eq("pullint_sp", 32'(sp_cnt), 32'hFD);
    tick();

    // PUSH_INT with brk=1 then brk=0
    for (int b = 1; b >= 0; b--) begin
      set_sp(8'hFF);
      kick(3'b011, 8'h00, 16'hABCD, 8'hC3, 1'(b));
      tick();
      check_eq("pushint_c1", {addr, 8'h00, wdata}, 32'h01FF_00AB);
      tick();
      check_eq("pushint_c2", {addr, 8'h00, wdata}, 32'h01FE_00CD);
      tick();
      check_eq("pushint_c3", {addr, 8'h00, wdata}, (b == 1) ? 32'h01FD_00F3 : 32'h01FD_00E3);
      tick();
      check_eq("pushint_c4_done", 32'(done), 32'h1);
      tick();
    end

    // PUSH1 twice at saturated sp=00
    set_sp(8'h00);
    kick(3'b000, 8'h7E, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("push1a_c1", {addr, 8'h00, wdata}, 32'h0100_007E);
    tick();
    check_eq("push1a_c2_done", 32'(done), 32'h1);
    check_eq("push1a_sp", 32'(sp_cnt), 32'h00);
    tick();
    kick(3'b000, 8'h11, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("push1b_c1", {addr, 8'h00, wdata}, 32'h0100_0011);
    check_eq("push1b_c1_we", 32'(we), 32'h1);
    tick();
    check_eq("push1b_c2_done", 32'(done), 32'h1);
    check_eq("push1b_sp", 32'(sp_cnt), 32'h00);
    check_eq("push1b_mem00", 32'(mem[8'h00]), 32'h11);
    tick();

    // Reserved op
    kick(3'b110, 8'h00, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("rsvd_c1_done", 32'(done), 32'h1);
    check_eq("rsvd_c1_err", 32'(err), 32'h1);
    check_eq("rsvd_c1_we", 32'(we), 32'h0);
    check_eq("rsvd_c1_sel", 32'(sp_sel), 32'h0);
    check_eq("rsvd_c1_busy", 32'(busy), 32'h0);
    check_eq("rsvd_c1_addr", 32'(addr), 32'h0);
    tick();
    check_eq("rsvd_c2_done", 32'(done), 32'h0);
    check_eq("rsvd_c2_err", 32'(err), 32'h0);

    // PULL_PC with start held through busy and DONE cycles
    poke(8'hF1, 8'h78);
    poke(8'hF2, 8'h56);
    set_sp(8'hF0);
    kick(3'b100, 8'h00, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("pullpc_c1_addr", 32'(addr), 32'h01F1);
    start = 1'b1; op = 3'b000; push_data = 8'hEE;
    tick();
    check_eq("pullpc_c2_addr", 32'(addr), 32'h01F2);
    check_eq("pullpc_c2_we", 32'(we), 32'h0);
    tick();
    check_eq("pullpc_c3_busy", 32'(busy), 32'h1);
    check_eq("pullpc_c3_sel", 32'(sp_sel), 32'h0);
    tick();
    check_eq("pullpc_c4_done", 32'(done), 32'h1);
    check_eq("pullpc_pcout", 32'(pc_out), 32'h5678);
    check_eq("pullpc_pout_kept", 32'(p_out), 32'hA5);
    check_eq("pullpc_err", 32'(err), 32'h0);
    tick();
    check_idle("pullpc_c5");
    start = 1'b0;
    tick();
    check_idle("pullpc_c6");

    // PULL1 leaves PC result untouched
    poke(8'hF3, 8'h9C);
    kick(3'b001, 8'h00, 16'h0000, 8'h00, 1'b0);
    tick();
    check_eq("pull1_c1_addr", 32'(addr), 32'h01F3);
    tick();
    check_eq("pull1_c2_done", 32'(done), 32'h0);
    tick();
    check_eq("pull1_c3_done", 32'(done), 32'h1);
    check_eq("pull1_data", 32'(pull_data), 32'h9C);
    check_eq("pull1_pcout_kept", 32'(pc_out), 32'h5678);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-byte stack transfer sequencer that sits directly upstream of the stack pointer.
- Drives the stack pointer's sel code and consumes its sp value to form stack-page bus addresses.
- Issues one write or read per clock for the 6502 sequences PHA/PHP, PLA/PLP, JSR, BRK/IRQ/NMI, RTS and RTI.
- Returns pulled bytes to the register file and PC logic with a start/done handshake.

Parameters:
- STACK_PAGE, 8'h01, high address byte of every stack access.
- ADDR_W, 16, bus address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  3  000 PUSH1, 001 PULL1, 010 PUSH_PC, 011 PUSH_INT, 100 PULL_PC, 101 PULL_INT, 110/111 reserved
- brk  in  1  for PUSH_INT: 1 sets the pushed P bit4 (B), 0 clears it
- push_data  in  8  byte for PUSH1
- pc  in  16  PC to push
- status  in  8  P register to push
- sp  in  8  stack pointer output
- mem_rdata  in  8  read data, valid the cycle after the address
- sp_sel  out  2  00 hold, 01 increment (pull), 10 decrement (push)
- addr  out  ADDR_W  {STACK_PAGE, sp} during access cycles, else 0
- wdata  out  8  write byte
- we  out  1  write strobe
- busy  out  1  high from the cycle after start until the cycle before done
- done  out  1  one-cycle completion pulse
- err  out  1  high with done for a reserved op
- pull_data  out  8  PULL1 result
- pc_out  out  16  PULL_PC/PULL_INT PC result
- p_out  out  8  PULL_INT status result

Behaviour:
- Reset (reset=0 at posedge): state IDLE. sp_sel=00, we=0, addr=0, wdata=0, busy=0, done=0, err=0, pull_data=0, pc_out=0, p_out=0.
- Reset mid-operation aborts immediately. No done pulse is produced, and no further we or sp_sel activity occurs.
- States: IDLE, XFER, WAIT, DONE.
- IDLE:
  - If start=1, latch op, push_data, pc, status and brk.
  - Set the byte index to 0 and the count n by op: PUSH1/PULL1=1, PUSH_PC/PULL_PC=2, PUSH_INT/PULL_INT=3.
  - Go to XFER.
  - A reserved op goes directly to DONE with err=1 and makes no bus access.
- XFER: one access per cycle; the index increments each cycle.
  - Push: we=1, sp_sel=10, addr={STACK_PAGE,sp}. The byte is written at the current sp, and the stack pointer decrements at the clock edge.
  - Pull: we=0, sp_sel=01. The stack pointer presents counter+1 combinationally, so addr={STACK_PAGE,sp} addresses the pre-increment value.
  - After the last access, a push goes to DONE and a pull goes to WAIT.
- Byte orders:
  - PUSH_PC: PCH, PCL.
  - PUSH_INT: PCH, PCL, then P with bit5 forced to 1 and bit4=brk.
  - PULL_PC: PCL, PCH.
  - PULL_INT: P, PCL, PCH.
- Pull capture: mem_rdata is sampled at the end of the cycle following each pull address. The capture is pipelined, so byte k is captured during access k+1 or during WAIT. WAIT lasts one cycle, sp_sel=00.
- DONE: one cycle; done=1 and sp_sel=00; then return to IDLE.
- Result outputs hold their value until the next pull of the same kind completes. Push operations do not modify them.
- Latency, start sampled at edge 0:
  - Push of n bytes: accesses in cycles 1..n, done in cycle n+1.
  - Pull of n bytes: accesses in cycles 1..n, WAIT in cycle n+1, done in cycle n+2.
- start while busy or during DONE: ignored, not queued.
- SP boundaries: the sequencer issues accesses unconditionally. The stack pointer saturates at 00 (push) and FF (pull), so repeated accesses re-hit the same address. No wrap into page 0x00 or 0x02 is ever generated.

Decomposition:
- Shared package cpu_stack_pkg:
  - op encodings
  - state enum
  - STACK_PAGE_DEFAULT
  - status bit indices: B=4, U=5
  - byte-count function op->n
- No sub-module is needed. Op decode and count stay inline; the FSM and datapath form one block.

Test Plan:
- reset=0 during PUSH_INT cycle 2 -> next cycle we=0, sp_sel=00, busy=0, no done; the results stay 0.
- sp=FD, PUSH_PC with pc=C123 -> we on 01FD=C1, then 01FC=23, sp_sel=10 both cycles, done in cycle 3, final sp=FB.
- sp=FA (counter), PULL_INT with memory 01FB=A5, 01FC=34, 01FD=12 -> addresses 01FB, 01FC, 01FD in cycles 1-3; done in cycle 5 with p_out=A5, pc_out=1234.
- PUSH_INT with status=C3, brk=1, sp=FF -> writes PCH@01FF, PCL@01FE, F3@01FD; with brk=0 the third byte is E3.
- PUSH1 data=7E at sp=00 then PUSH1 data=11 -> both write 0100; sp stays 00; each done follows 1 cycle after its access.
- op=110 -> done=1 and err=1 in cycle 1, no we, sp_sel=00. A start pulse during a busy PULL_PC is ignored, and that PULL_PC completes normally.
